// File: rtl/mem_arbiter.sv
// Purpose : shares one synchronous memory between the CPU (m0) and the monitor/debug master (m1).
// Latency : ack and memory issue are combinational in the request cycle; read data returns one cycle after ack.
// Backpressure: a master holds req and its payload until ack. m0 has fixed priority, m1 is served after
//               STARVE_LIMIT consecutive m0 grants, and m1_lock stalls m0 entirely.
// Ports:
//   clk, reset (sync, active-low)
//   m0_* / m1_* : req/wen/addr/wdata in; ack/rdata/rvalid out
//   m1_lock in, m1_locked out
//   mem_*       : cs/wen/addr/wdata out, rdata in
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDR_SIZE    = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_req,
    input  logic                 m0_wen,
    input  logic [ADDR_SIZE-1:0] m0_addr,
    input  logic [WIDTH-1:0]     m0_wdata,
    output logic                 m0_ack,
    output logic [WIDTH-1:0]     m0_rdata,
    output logic                 m0_rvalid,
    input  logic                 m1_req,
    input  logic                 m1_wen,
    input  logic [ADDR_SIZE-1:0] m1_addr,
    input  logic [WIDTH-1:0]     m1_wdata,
    output logic                 m1_ack,
    output logic [WIDTH-1:0]     m1_rdata,
    output logic                 m1_rvalid,
    input  logic                 m1_lock,
    output logic                 m1_locked,
    output logic                 mem_cs,
    output logic                 mem_wen,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]     mem_wdata,
    input  logic [WIDTH-1:0]     mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic [3:0] streak_nxt;
    logic       gnt0;
    logic       gnt1;
    logic       rd_own0;
    logic       rd_own1;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (m1_lock)  state_nxt = LOCKED;
            LOCKED:  if (!m1_lock) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // Grant logic. Grants are suppressed while reset is low so nothing is
    // issued to memory (and no read is tagged) during reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            case (state)
                ARB: begin
                    if (m1_lock) begin
                        // Lock request wins over everything, including starvation relief.
                        gnt1 = m1_req;
                    end else if (m0_req && m1_req) begin
                        if (streak == LIMIT) gnt1 = 1'b1;
                        else                 gnt0 = 1'b1;
                    end else begin
                        gnt0 = m0_req;
                        gnt1 = m1_req;
                    end
                end
                LOCKED:  gnt1 = m1_req;
                default: ;
            endcase
        end
    end

    // Starvation counter: counts m0 grants taken while m1 was waiting.
    always_comb begin
        streak_nxt = streak;
        if (state == LOCKED && !m1_lock) begin
            streak_nxt = 4'd0;
        end else if (gnt1 || !m1_req) begin
            streak_nxt = 4'd0;
        end else if (gnt0 && streak < LIMIT) begin
            streak_nxt = streak + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            streak <= 4'd0;
        end else begin
            streak <= streak_nxt;
        end
    end

    // Read owner tags: memory returns data the cycle after a read is issued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_own0 <= 1'b0;
            rd_own1 <= 1'b0;
        end else begin
            rd_own0 <= gnt0 && !m0_wen;
            rd_own1 <= gnt1 && !m1_wen;
        end
    end

    assign m0_ack    = gnt0;
    assign m1_ack    = gnt1;
    assign m1_locked = (state == LOCKED);

    assign mem_cs    = gnt0 || gnt1;
    assign mem_wen   = gnt1 ? m1_wen   : (gnt0 ? m0_wen   : 1'b0);
    assign mem_addr  = gnt1 ? m1_addr  : (gnt0 ? m0_addr  : '0);
    assign mem_wdata = gnt1 ? m1_wdata : (gnt0 ? m0_wdata : '0);

    assign m0_rvalid = rd_own0;
    assign m1_rvalid = rd_own1;
    assign m0_rdata  = rd_own0 ? mem_rdata : '0;
    assign m1_rdata  = rd_own1 ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose : self-checking bench for mem_arbiter with a behavioural synchronous memory.
// Latency : one vector or hand sequence step per clock; outputs sampled on the falling edge.
// Backpressure: stimulus holds each request until the expected ack cycle.
module tb_mem_arbiter;
    localparam int W = 32;
    localparam int A = 12;

    logic         clk = 1'b0;
    logic         reset;
    logic         m0_req, m0_wen, m0_ack, m0_rvalid;
    logic [A-1:0] m0_addr;
    logic [W-1:0] m0_wdata, m0_rdata;
    logic         m1_req, m1_wen, m1_ack, m1_rvalid;
    logic [A-1:0] m1_addr;
    logic [W-1:0] m1_wdata, m1_rdata;
    logic         m1_lock, m1_locked;
    logic         mem_cs, mem_wen;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(W), .ADDR_SIZE(A), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
        .m1_lock(m1_lock), .m1_locked(m1_locked),
        .mem_cs(mem_cs), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural single-port synchronous memory.
    logic [W-1:0] mem [0:(1<<A)-1];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_wen) mem[mem_addr] <= mem_wdata;
            else         mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        logic         rst;
        logic         r0, w0;
        logic [A-1:0] a0;
        logic [W-1:0] d0;
        logic         r1, w1;
        logic [A-1:0] a1;
        logic [W-1:0] d1;
        logic         lk;
        logic         e_ack0, e_ack1, e_rv0;
        logic [W-1:0] e_rd0;
        logic         e_rv1;
        logic [W-1:0] e_rd1;
        logic         e_lkd, e_cs;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    int passed = 0;
    int total  = 0;

    function automatic vec_t mk(
        input logic rst, input logic r0, input logic w0, input logic [A-1:0] a0, input logic [W-1:0] d0,
        input logic r1, input logic w1, input logic [A-1:0] a1, input logic [W-1:0] d1, input logic lk,
        input logic e_ack0, input logic e_ack1, input logic e_rv0, input logic [W-1:0] e_rd0,
        input logic e_rv1, input logic [W-1:0] e_rd1, input logic e_lkd, input logic e_cs);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.lk = lk;
        v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_rv0 = e_rv0; v.e_rd0 = e_rd0;
        v.e_rv1 = e_rv1; v.e_rd1 = e_rd1; v.e_lkd = e_lkd; v.e_cs = e_cs;
        return v;
    endfunction

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    task automatic drive(
        input logic rst, input logic r0, input logic w0, input logic [A-1:0] a0, input logic [W-1:0] d0,
        input logic r1, input logic w1, input logic [A-1:0] a1, input logic [W-1:0] d1, input logic lk);
        reset = rst;
        m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
        m1_lock = lk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rst r0 w0 a0      d0            r1 w1 a1      d1            lk  ack0 ack1 rv0 rd0           rv1 rd1           lkd cs
        // Reset held with both masters requesting: nothing issued.
        vt[0]  = mk(0, 1, 0, 12'h010, 32'h0,        1, 0, 12'h000, 32'h0,        0,  0, 0, 0, 32'h0,        0, 32'h0,        0, 0);
        vt[1]  = mk(0, 1, 0, 12'h010, 32'h0,        1, 0, 12'h000, 32'h0,        0,  0, 0, 0, 32'h0,        0, 32'h0,        0, 0);
        vt[2]  = mk(0, 1, 0, 12'h010, 32'h0,        1, 0, 12'h000, 32'h0,        0,  0, 0, 0, 32'h0,        0, 32'h0,        0, 0);
        vt[3]  = mk(1, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0,  0, 0, 0, 32'h0,        0, 32'h0,        0, 0);
        // m0 write then read-back; data one cycle after the read ack.
        vt[4]  = mk(1, 1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h000, 32'h0,        0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 1);
        vt[5]  = mk(1, 1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 1);
        vt[6]  = mk(1, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0,  0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0);
        vt[7]  = mk(1, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0,  0, 0, 0, 32'h0,        0, 32'h0,        0, 0);
        // m0 read, then lock with m0 still requesting.
        vt[8]  = mk(1, 1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        0,  1, 0, 0, 32'h0,        0, 32'h0,        0, 1);
        vt[9]  = mk(1, 1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        1,  0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0);
        vt[10] = mk(1, 1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        1,  0, 0, 0, 32'h0,        0, 32'h0,        1, 0);
        vt[11] = mk(1, 1, 0, 12'h010, 32'h0,        1, 1, 12'h020, 32'h12345678, 1,  0, 1, 0, 32'h0,        0, 32'h0,        1, 1);
        vt[12] = mk(1, 1, 0, 12'h010, 32'h0,        1, 0, 12'h020, 32'h0,        1,  0, 1, 0, 32'h0,        0, 32'h0,        1, 1);
        // Lock dropped: m1 still served in the exit cycle, m0 the cycle after.
        vt[13] = mk(1, 1, 0, 12'h010, 32'h0,        1, 0, 12'h010, 32'h0,        0,  0, 1, 0, 32'h0,        1, 32'h12345678, 1, 1);
        vt[14] = mk(1, 1, 0, 12'h010, 32'h0,        0, 0, 12'h000, 32'h0,        0,  1, 0, 0, 32'h0,        1, 32'hDEADBEEF, 0, 1);
        vt[15] = mk(1, 0, 0, 12'h000, 32'h0,        0, 0, 12'h000, 32'h0,        0,  0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0);

        drive(0, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
        tick();
        tick();

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].rst, vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0,
                  vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1, vt[i].lk);
            @(negedge clk);
            chkb($sformatf("row%0d m0_ack", i),    m0_ack,    vt[i].e_ack0);
            chkb($sformatf("row%0d m1_ack", i),    m1_ack,    vt[i].e_ack1);
            chkb($sformatf("row%0d m0_rvalid", i), m0_rvalid, vt[i].e_rv0);
            chkw($sformatf("row%0d m0_rdata", i),  m0_rdata,  vt[i].e_rd0);
            chkb($sformatf("row%0d m1_rvalid", i), m1_rvalid, vt[i].e_rv1);
            chkw($sformatf("row%0d m1_rdata", i),  m1_rdata,  vt[i].e_rd1);
            chkb($sformatf("row%0d m1_locked", i), m1_locked, vt[i].e_lkd);
            chkb($sformatf("row%0d mem_cs", i),    mem_cs,    vt[i].e_cs);
            tick();
        end

        // Continuous contention: m0,m0,m0,m0,m1 repeating.
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 0, 12'h010, 32'h0, 1, 0, 12'h001, 32'h0, 0);
            @(negedge clk);
            chkb($sformatf("starve%0d m0_ack", i), m0_ack, (i % 5) != 4);
            chkb($sformatf("starve%0d m1_ack", i), m1_ack, (i % 5) == 4);
            tick();
        end

        // m1 alone: 8 back-to-back writes, then 8 back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 12'h0, 32'h0, 1, 1, A'(i), 32'hA5000000 + 32'(i), 0);
            @(negedge clk);
            chkb($sformatf("m1wr%0d m1_ack", i), m1_ack, 1'b1);
            tick();
        end
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) drive(1, 0, 0, 12'h0, 32'h0, 1, 0, A'(i), 32'h0, 0);
            else       drive(1, 0, 0, 12'h0, 32'h0, 0, 0, 12'h0, 32'h0, 0);
            @(negedge clk);
            chkb($sformatf("m1rd%0d m1_ack", i), m1_ack, i < 8);
            chkb($sformatf("m1rd%0d m1_rvalid", i), m1_rvalid, i > 0);
            chkw($sformatf("m1rd%0d m1_rdata", i), m1_rdata,
                 (i > 0) ? 32'hA5000000 + 32'(i - 1) : 32'h0);
            chkb($sformatf("m1rd%0d m0_rvalid", i), m0_rvalid, 1'b0);
            tick();
        end

        // Build up a streak of 3, then reset with a read and a lock request pending.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 12'h010, 32'h0, 1, 0, 12'h001, 32'h0, 0);
            tick();
        end
        drive(0, 1, 0, 12'h010, 32'h0, 1, 0, 12'h001, 32'h0, 1);
        @(negedge clk);
        chkb("rst m0_ack", m0_ack, 1'b0);
        chkb("rst m1_ack", m1_ack, 1'b0);
        chkb("rst mem_cs", mem_cs, 1'b0);
        tick();
        // After reset: no read data, not locked, streak restarted from 0.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 12'h010, 32'h0, 1, 0, 12'h001, 32'h0, 0);
            @(negedge clk);
            if (i == 0) begin
                chkb("post_rst m0_rvalid", m0_rvalid, 1'b0);
                chkb("post_rst m1_rvalid", m1_rvalid, 1'b0);
            end
            chkb($sformatf("post_rst%0d m1_locked", i), m1_locked, 1'b0);
            chkb($sformatf("post_rst%0d m0_ack", i), m0_ack, i != 4);
            chkb($sformatf("post_rst%0d m1_ack", i), m1_ack, i == 4);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single synchronous program/data memory inside comp between two masters.
- m0 is the p12 CPU; m1 is the monitor/debug master, used for program load, memory inspection and halting the CPU.
- Fixed priority to m0, bounded starvation for m1, and a lock mode that gives m1 exclusive ownership while the CPU is stalled.

Parameters:
- WIDTH, 32, data width of both masters and the memory.
- ADDR_SIZE, 12, address width (matches MEM_ADDR_SIZE of comp).
- STARVE_LIMIT, 4, maximum consecutive m0 grants while m1 is waiting (legal range 1..15).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- m0_req  in  1  CPU transaction request.
- m0_wen  in  1  CPU write enable (1 = write, 0 = read).
- m0_addr  in  ADDR_SIZE  CPU address.
- m0_wdata  in  WIDTH  CPU write data.
- m0_ack  out  1  CPU transaction issued this cycle.
- m0_rdata  out  WIDTH  CPU read data.
- m0_rvalid  out  1  CPU read data valid.
- m1_req, m1_wen, m1_addr, m1_wdata  in  1/1/ADDR_SIZE/WIDTH  monitor request, same meaning as m0.
- m1_ack, m1_rdata, m1_rvalid  out  1/WIDTH/1  monitor response, same meaning as m0.
- m1_lock  in  1  monitor requests exclusive bus ownership.
- m1_locked  out  1  exclusive ownership in effect.
- mem_cs  out  1  memory chip select.
- mem_wen  out  1  memory write enable.
- mem_addr  out  ADDR_SIZE  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data, valid one cycle after a read cs.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=ARB, streak=0, m1_locked=0.
  - m0_rvalid=m1_rvalid=0; pending read tag cleared.
  - With no req, all combinational outputs are 0.
- Issue:
  - Winner selected combinationally each cycle.
  - Winner's ack=1 in the same cycle; mem_cs=1; mem_wen/addr/wdata are the winner's inputs.
  - No winner: mem_cs=0, mem_wen=0, mem_addr=0, mem_wdata=0.
  - Masters hold req/wen/addr/wdata stable until ack; one transaction per cycle; back-to-back issue is allowed.
- Read return:
  - Read ack registers an owner tag.
  - Next cycle: that master's rvalid=1 and rdata=mem_rdata.
  - Non-owner rdata=0. Writes never raise rvalid. Latency ack-to-rvalid is exactly 1 cycle.
- ARB state arbitration:
  - Only one req: grant it.
  - Both req: grant m1 if streak==STARVE_LIMIT, else m0.
  - streak (4-bit): +1 when m0 granted while m1_req=1; cleared when m1 granted or m1_req=0; never exceeds STARVE_LIMIT.
- Lock entry:
  - m1_lock=1 in ARB: m0 is not granted that cycle; m1 may be granted.
  - Next cycle: state=LOCKED, m1_locked=1.
- LOCKED state:
  - Only m1 is served; m0_ack=0 regardless of m0_req.
  - An m0 read acked before lock entry still gets its rvalid.
- Lock exit:
  - m1_lock=0 in LOCKED: next cycle state=ARB, m1_locked=0, streak=0.
  - m1 may still be granted in the exit cycle.
- Simultaneous events:
  - Lock request and starvation together: lock takes precedence.
  - Reset overrides everything; a read acked in the cycle reset is sampled produces no rvalid.
- No combinational path from mem_rdata to any ack/cs signal.

Test Plan:
- Reset held low 3 cycles with both reqs high -> acks 0 while reset=0; after release state=ARB, m1_locked=0.
- m0 write addr 0x010 data 0xDEADBEEF, then m0 read 0x010 -> m0_ack in issue cycles; m0_rvalid=1 with m0_rdata=0xDEADBEEF exactly 1 cycle after read ack; m1_rvalid stays 0.
- Both masters request continuously, STARVE_LIMIT=4 -> grant pattern m0,m0,m0,m0,m1 repeating; m1_ack every 5th cycle.
- m1_req alone, 8 back-to-back reads of 0x000..0x007 -> m1_ack every cycle; 8 consecutive m1_rvalid pulses, each one cycle late, data in address order.
- m0 issues a read; in the following cycle m1_lock=1 with m0_req held -> m0_rvalid still delivered; m1_locked=1 next cycle; m0_ack=0 for the whole lock. Drop m1_lock -> m1_locked=0 next cycle and m0 granted the cycle after.
- Reset asserted in the cycle a read is acked -> no rvalid follows, m1_locked=0, streak=0.
